// File: rtl/snn_pkg.sv
// snn_pkg: shared packet layout, type codes and sizing constants for the
// adder/PE/collector spike path.
package snn_pkg;
  localparam int WIDTH = 64;
  localparam int MAP_DIM = 21;
  localparam logic [3:0] MY_ADDRESS_DEF = 4'b1010;
  localparam int NUM_ADDERS_DEF = 7;
  localparam int DEST_LSB = 60;
  localparam int SRC_LSB = 56;
  localparam int TYPE_LSB = 54;
  localparam logic [9:0] DONE_PAYLOAD = 10'h3FF;
  typedef enum logic [1:0] {PT_FLAG = 2'b10, PT_SPIKE = 2'b11} pkt_type_e;
  typedef enum logic {COLLECT, READOUT} state_e;
  typedef struct packed {
    logic [3:0]  dest;
    logic [3:0]  src;
    logic [1:0]  typ;
    logic [43:0] zero;
    logic [9:0]  payload;
  } pkt_t;
endpackage

// File: rtl/spike_collector_if.sv
// spike_collector_if: packet-in and row-out handshakes of the spike collector.
//   in_valid/in_ready/in_data     : 64-bit packet stream from the adders
//   row_valid/row_ready/row_idx/row_data/row_last : spike map readout stream
//   slave = collector side, master = producer/consumer side
interface spike_collector_if import snn_pkg::*; ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               row_valid;
  logic               row_ready;
  logic [4:0]         row_idx;
  logic [MAP_DIM-1:0] row_data;
  logic               row_last;
  modport slave (input in_valid, in_data, row_ready,
                 output in_ready, row_valid, row_idx, row_data, row_last);
  modport master (output in_valid, in_data, row_ready,
                  input in_ready, row_valid, row_idx, row_data, row_last);
endinterface

// File: rtl/spike_collector_map_rf.sv
// spike_map_rf: MAP_DIM x MAP_DIM bit array.
//   set_i/set_x_i/set_y_i : set one bit; old_o returns its value before the set
//   rd_x_i/rd_data_o      : combinational row read
//   clr_i                 : synchronous clear of the whole array
module spike_map_rf import snn_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_i,
  input  logic [4:0]         set_x_i,
  input  logic [4:0]         set_y_i,
  output logic               old_o,
  input  logic [4:0]         rd_x_i,
  output logic [MAP_DIM-1:0] rd_data_o,
  input  logic               clr_i
);
  logic [MAP_DIM-1:0][MAP_DIM-1:0] map_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) map_q <= '0;
    else if (clr_i) map_q <= '0;
    else if (set_i) map_q[set_x_i][set_y_i] <= 1'b1;
  end
  always_comb begin
    old_o = map_q[set_x_i][set_y_i];
    rd_data_o = map_q[rd_x_i];
  end
endmodule

// File: rtl/spike_collector.sv
// spike_collector: decodes spike packets into an output spike map, counts
// per-source done markers and streams the map out once all adders are done.
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus           : packet input / row output handshakes (slave modport)
//   timestep_o    : completed-timestep count (wraps at 8 bits)
//   spike_count_o : distinct spikes of the last completed timestep
//   err_status_o  : sticky {dup_done, bad_type, bad_coord, bad_dest}
module spike_collector import snn_pkg::*; #(
  parameter logic [3:0] MY_ADDRESS = MY_ADDRESS_DEF,
  parameter int         NUM_ADDERS = NUM_ADDERS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spike_collector_if.slave      bus,
  output logic [7:0]            timestep_o,
  output logic [8:0]            spike_count_o,
  output logic [3:0]            err_status_o
);
  state_e state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [15:0] mask_q, mask_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic [8:0]  run_q, run_d, spk_q, spk_d;
  logic [7:0]  ts_q, ts_d;
  logic [3:0]  err_q, err_d;
  pkt_t pkt;
  logic acc, dest_ok, type_ok, is_done, coord_ok, good, done_new, dup, spike_set;
  logic row_hs, last_hs, fin, old_bit;
  logic [MAP_DIM-1:0] rd_row;
  logic unused_zero;
  spike_map_rf u_map (
    .clk(clk), .rst_n(rst_n),
    .set_i(spike_set), .set_x_i(pkt.payload[9:5]), .set_y_i(pkt.payload[4:0]),
    .old_o(old_bit), .rd_x_i(row_q), .rd_data_o(rd_row), .clr_i(last_hs)
  );
  always_comb begin
    pkt = bus.in_data;
    unused_zero = ^pkt.zero;
    acc = bus.in_valid && bus.in_ready;
    dest_ok = pkt.dest == MY_ADDRESS;
    type_ok = pkt.typ == PT_SPIKE;
    is_done = pkt.payload == DONE_PAYLOAD;
    coord_ok = pkt.payload[9:5] < 5'(MAP_DIM) && pkt.payload[4:0] < 5'(MAP_DIM);
    good = acc && dest_ok && type_ok;
    done_new = good && is_done && !mask_q[pkt.src];
    dup = good && is_done && mask_q[pkt.src];
    spike_set = good && !is_done && coord_ok;
    fin = done_new && dcnt_q == 4'(NUM_ADDERS - 1);
    row_hs = bus.row_valid && bus.row_ready;
    last_hs = row_hs && bus.row_last;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == COLLECT ? (fin ? READOUT : COLLECT)
                                 : (last_hs ? COLLECT : READOUT);
  end
  // in_ready is gated by rst_n so it stays low while reset is held
  always_comb begin
    bus.in_ready = rst_n && state_q == COLLECT;
    bus.row_valid = state_q == READOUT;
    bus.row_idx = row_q;
    bus.row_data = bus.row_valid ? rd_row : '0;
    bus.row_last = bus.row_valid && row_q == 5'(MAP_DIM - 1);
    timestep_o = ts_q;
    spike_count_o = spk_q;
    err_status_o = err_q;
  end
  always_comb begin
    mask_d = last_hs ? '0 : done_new ? mask_q | (16'b1 << pkt.src) : mask_q;
    dcnt_d = last_hs ? '0 : dcnt_q + 4'(done_new);
    run_d = last_hs ? '0 : run_q + 9'(spike_set && !old_bit);
    spk_d = fin ? run_q : spk_q;
    ts_d = ts_q + 8'(last_hs);
    row_d = last_hs ? '0 : row_q + 5'(row_hs);
    err_d = err_q | {dup, acc && dest_ok && !type_ok, good && !is_done && !coord_ok, acc && !dest_ok};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      dcnt_q <= '0;
      run_q <= '0;
      spk_q <= '0;
      ts_q <= '0;
      row_q <= '0;
      err_q <= '0;
    end else begin
      mask_q <= mask_d;
      dcnt_q <= dcnt_d;
      run_q <= run_d;
      spk_q <= spk_d;
      ts_q <= ts_d;
      row_q <= row_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_spike_collector.sv
// tb_spike_collector: directed and randomized checks of spike_collector against a map/set reference model.
module tb_spike_collector;
  import snn_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] ts;
  logic [8:0] sc;
  logic [3:0] es;
  int tests = 0;
  int fails = 0;
  bit ref_map[21][21];
  bit ref_done[16];
  int ref_ndone;
  logic [3:0] ref_err;
  logic [7:0] ref_ts;
  int ref_spk;
  bit ref_ro;

  always #5 clk = ~clk;

  spike_collector_if bus();
  spike_collector dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                       .timestep_o(ts), .spike_count_o(sc), .err_status_o(es));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int d, input int s, input int t, input int pay);
    return (64'(d) << 60) | (64'(s) << 56) | (64'(t) << 54) | 64'(pay);
  endfunction

  function automatic int sp(input int x, input int y);
    return x * 32 + y;
  endfunction

  task automatic clear_timestep();
    foreach (ref_map[i, j]) ref_map[i][j] = 0;
    foreach (ref_done[i]) ref_done[i] = 0;
    ref_ndone = 0;
    ref_ro = 0;
  endtask

  task automatic model(input logic [63:0] p);
    int d, s, t, pay, x, y;
    d = int'(p >> 60);
    s = int'((p >> 56) & 64'hF);
    t = int'((p >> 54) & 64'h3);
    pay = int'(p & 64'h3FF);
    x = pay / 32;
    y = pay % 32;
    if (d != 10) ref_err |= 4'd1;
    else if (t != 3) ref_err |= 4'd4;
    else if (pay == 1023) begin
      if (ref_done[s]) ref_err |= 4'd8;
      else begin
        ref_done[s] = 1;
        ref_ndone++;
      end
    end else if (x > 20 || y > 20) ref_err |= 4'd2;
    else ref_map[x][y] = 1;
    if (ref_ndone == 7 && !ref_ro) begin
      ref_ro = 1;
      ref_spk = 0;
      foreach (ref_map[i, j]) ref_spk += int'(ref_map[i][j]);
    end
  endtask

  task automatic send(input logic [63:0] p);
    chk("in_ready", bus.in_ready, 1);
    bus.in_valid = 1;
    bus.in_data = p;
    @(negedge clk);
    bus.in_valid = 0;
    model(p);
    chk("err_status", es, ref_err);
    chk("row_valid", bus.row_valid, ref_ro);
    if (ref_ro) begin
      chk("readout_in_ready", bus.in_ready, 0);
      chk("spike_count", sc, ref_spk);
      chk("first_row_idx", bus.row_idx, 0);
    end
  endtask

  task automatic done_all();
    for (int s = 0; s < 7; s++) send(pk(10, s, 3, 1023));
  endtask

  task automatic readout(input int stall_row, input int stall_n, input bit poke);
    logic [20:0] exp;
    for (int r = 0; r < 21; r++) begin
      exp = '0;
      for (int y = 0; y < 21; y++) exp[y] = ref_map[r][y];
      chk("rd_valid", bus.row_valid, 1);
      chk("rd_idx", bus.row_idx, r);
      chk("rd_data", bus.row_data, exp);
      chk("rd_last", bus.row_last, r == 20);
      chk("rd_in_ready", bus.in_ready, 0);
      if (r == stall_row) begin
        bus.row_ready = 0;
        for (int k = 0; k < stall_n; k++) begin
          @(negedge clk);
          chk("hold_valid", bus.row_valid, 1);
          chk("hold_idx", bus.row_idx, r);
          chk("hold_data", bus.row_data, exp);
        end
      end
      bus.row_ready = 1;
      if (poke) begin
        bus.in_valid = 1;
        bus.in_data = pk(10, 0, 3, sp(7, 7));
      end
      @(negedge clk);
    end
    bus.row_ready = 0;
    bus.in_valid = 0;
    clear_timestep();
    ref_ts++;
    chk("post_row_valid", bus.row_valid, 0);
    chk("post_in_ready", bus.in_ready, 1);
    chk("timestep", ts, ref_ts);
    chk("post_spike_count", sc, ref_spk);
    chk("post_err", es, ref_err);
  endtask

  task automatic do_reset();
    rst_n = 0;
    bus.in_valid = 0;
    bus.row_ready = 0;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_row_valid", bus.row_valid, 0);
    chk("rst_row_idx", bus.row_idx, 0);
    chk("rst_row_data", bus.row_data, 0);
    chk("rst_row_last", bus.row_last, 0);
    chk("rst_timestep", ts, 0);
    chk("rst_spike_count", sc, 0);
    chk("rst_err", es, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rel_in_ready", bus.in_ready, 1);
    clear_timestep();
    ref_err = 0;
    ref_ts = 0;
    ref_spk = 0;
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int n, g, kind, d, t, x, y;
    logic [63:0] p;
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.row_ready = 0;
    do_reset();
    send(pk(10, 1, 3, sp(0, 6)));
    send(pk(10, 2, 3, sp(20, 20)));
    send(pk(10, 3, 3, sp(3, 13)));
    done_all();
    readout(-1, 0, 0);
    for (int i = 0; i < 3; i++) send(pk(10, 4, 3, sp(5, 5)));
    done_all();
    readout(4, 5, 1);
    send(pk(3, 0, 3, sp(2, 2)));
    send(pk(10, 0, 2, sp(2, 2)));
    send(pk(10, 0, 3, sp(21, 0)));
    chk("err_0111", es, 4'b0111);
    done_all();
    readout(-1, 0, 0);
    send(pk(10, 2, 3, 1023));
    send(pk(10, 2, 3, 1023));
    foreach (ref_done[i]) if (i < 6 && i != 2) send(pk(10, i, 3, 1023));
    chk("no_readout_at_6", bus.row_valid, 0);
    send(pk(10, 6, 3, 1023));
    readout(-1, 0, 0);
    for (int s = 0; s < 3; s++) send(pk(10, s, 3, 1023));
    do_reset();
    send(pk(10, 5, 3, sp(1, 1)));
    done_all();
    readout(-1, 0, 0);
    for (int step = 0; step < 6; step++) begin
      n = 0;
      while (!ref_ro && n < 400) begin
        kind = $urandom_range(0, 9);
        d = 10;
        t = 3;
        x = $urandom_range(0, 20);
        y = $urandom_range(0, 20);
        if (kind == 0) begin
          d = $urandom_range(0, 15);
          if (d == 10) d = 11;
        end else if (kind == 1) t = $urandom_range(0, 2);
        else if (kind == 4) begin
          x = $urandom_range(21, 31);
          y = $urandom_range(0, 30);
        end
        p = pk(d, $urandom_range(0, 15), t, sp(x, y));
        if (kind == 2 || kind == 3) p = pk(10, $urandom_range(0, 6), 3, 1023);
        p |= {$urandom, $urandom} & 64'h003F_FFFF_FFFF_FC00;
        send(p);
        n++;
      end
      readout($urandom_range(0, 20), $urandom_range(0, 3), 1);
    end
    g = 0;
    do begin
      done_all();
      readout(-1, 0, 0);
      g++;
    end while (ref_ts != 0 && g < 300);
    chk("wrap_timestep", ts, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
